eco32_core_ifu_imm_seq: RTL and testbench

//  Pipelined immediate-constant sequencer in the IFU, between the instruction-way read and the decoder.

---
 rtl/eco32_core_ifu_imm_pkg.sv | 71 +++++++
 rtl/eco32_core_ifu_imm_dec.sv | 53 +++++
 rtl/eco32_core_ifu_imm_seq.sv | 183 ++++++++++++++++++
 tb/tb_eco32_core_ifu_imm_seq.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/eco32_core_ifu_imm_pkg.sv
// eco32 IFU immediate sequencer: shared select encodings,
// ldi/lra opcodes, pair FSM states and the immediate mux.
package eco32_core_ifu_imm_pkg;

  localparam logic [1:0] LX_LO_13  = 2'd0;
  localparam logic [1:0] LX_ADR_11 = 2'd1;
  localparam logic [1:0] LX_ADR_10 = 2'd2;
  localparam logic [1:0] LX_ZERO   = 2'd3;

  localparam logic [1:0] MX_MI_6   = 2'd0;
  localparam logic [1:0] MX_LO_SGN = 2'd1;
  localparam logic [1:0] MX_ZERO   = 2'd3;

  localparam logic [2:0] HX_LO_SGN = 3'd0;
  localparam logic [2:0] HX_MI_SGN = 3'd1;
  localparam logic [2:0] HX_SIG_6  = 3'd2;
  localparam logic [2:0] HX_UNS_6  = 3'd3;
  localparam logic [2:0] HX_LO_13  = 3'd4;
  localparam logic [2:0] HX_ZERO   = 3'd7;

  localparam logic [5:0] OPC_LDI = 6'h38;
  localparam logic [5:0] OPC_LRA = 6'h39;

  typedef enum logic {
    ST_IDLE,
    ST_HOLD
  } pair_st_e;

  typedef struct packed {
    logic [2:0] h;
    logic [1:0] m;
    logic [1:0] l;
  } imm_sel_t;

  function automatic logic is_pair_opc(
    input logic [5:0] op
  );
    return (op == OPC_LDI) | (op == OPC_LRA);
  endfunction

  // Only iw[18:0] feeds the immediate fields.
  function automatic logic [31:0] imm_mux(
    input logic [18:0] iw,
    input imm_sel_t    s
  );
    logic [12:0] hv;
    logic [5:0]  mv;
    logic [12:0] lv;
    case (s.l)
      LX_LO_13:  lv = iw[12:0];
      LX_ADR_11: lv = {iw[10:0], 2'b0};
      LX_ADR_10: lv = {iw[9:0], 3'b0};
      default:   lv = '0;
    endcase
    case (s.m)
      MX_MI_6:   mv = iw[18:13];
      MX_LO_SGN: mv = {6{iw[12]}};
      default:   mv = '0;
    endcase
    case (s.h)
      HX_LO_SGN: hv = {13{iw[12]}};
      HX_MI_SGN: hv = {13{iw[18]}};
      HX_SIG_6:  hv = {{7{iw[18]}}, iw[18:13]};
      HX_UNS_6:  hv = {7'b0, iw[18:13]};
      HX_LO_13:  hv = iw[12:0];
      default:   hv = '0;
    endcase
    return {hv, mv, lv};
  endfunction

endpackage

// File: rtl/eco32_core_ifu_imm_dec.sv
// eco32 IFU immediate select decoder (combinational).
// i_mopc/i_m/i_p0 in -> o_sel {H,M,L} mux selects out.
module eco32_core_ifu_imm_dec
  import eco32_core_ifu_imm_pkg::*;
(
  input  logic [5:0] i_mopc,
  input  logic       i_m,
  input  logic       i_p0,
  output imm_sel_t   o_sel
);

  logic [5:0] op;
  logic g_sx, g_hi, g_19, g_ax, g_a10;
  logic g_a11, g_32, g_34, g_ld;

  assign op = i_mopc;
  // 00-0F and 20-2B share the sign-extended lo13 form
  assign g_sx  = (op[5:4] == 2'b00) |
                 ((op[5:4] == 2'b10) &
                  (op[3:2] != 2'b11));
  assign g_hi  = (op[5:2] == 4'b0100);
  assign g_19  = (op == 6'h19);
  assign g_ax  = (op[5:2] == 4'b1011);
  assign g_a10 = (op == 6'h33) | (op == 6'h36) |
                 (op == 6'h37);
  assign g_a11 = (op == 6'h31) | (op == 6'h35);
  assign g_32  = (op == 6'h32);
  assign g_34  = (op == 6'h34);
  assign g_ld  = is_pair_opc(op);

  always_comb begin
    o_sel = '{h: HX_ZERO, m: MX_ZERO, l: LX_ZERO};
    unique case (1'b1)
      g_sx:  o_sel = '{HX_LO_SGN, MX_LO_SGN, LX_LO_13};
      g_hi:  o_sel = '{HX_LO_13, MX_ZERO, LX_ZERO};
      g_19:  o_sel = '{HX_ZERO, MX_ZERO, LX_LO_13};
      g_ax:  o_sel = '{HX_LO_SGN, MX_LO_SGN, LX_ADR_10};
      g_a10: o_sel = '{HX_ZERO, MX_ZERO, LX_ADR_10};
      g_a11: o_sel = '{i_p0 ? HX_ZERO : HX_MI_SGN,
                       MX_MI_6, LX_ADR_11};
      g_32:  o_sel = i_p0 ?
               '{HX_ZERO, MX_ZERO, LX_ADR_11} :
               '{HX_LO_SGN, MX_LO_SGN, LX_ADR_11};
      g_34:  o_sel = '{i_p0 ? HX_UNS_6 : HX_SIG_6,
                       MX_MI_6, LX_ADR_11};
      g_ld:  o_sel = i_m ?
               '{HX_LO_13, MX_MI_6, LX_ZERO} :
               '{HX_MI_SGN, MX_MI_6, LX_LO_13};
      default: ;
    endcase
  end

endmodule

// File: rtl/eco32_core_ifu_imm_seq.sv
// eco32 IFU immediate sequencer: 2-stage decode/assemble with
// optional ldi/lra half pairing (macro ECO32_IFU_IMM_PAIR_EN).
// In:  clk, rst_n, i_flush, i_stb, i_iw, i_p0, i_rdy
// Out: o_rdy, o_stb, o_iw, o_imm, o_pair
module eco32_core_ifu_imm_seq
  import eco32_core_ifu_imm_pkg::*;
#(
  parameter int unsigned HOLD_TMO = 15
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_flush,
  input  logic        i_stb,
  input  logic [31:0] i_iw,
  input  logic        i_p0,
  output logic        o_rdy,
  output logic        o_stb,
  output logic [31:0] o_iw,
  output logic [31:0] o_imm,
  output logic        o_pair,
  input  logic        i_rdy
);

  imm_sel_t    dec_sel;
  logic        a_vld_q, a_vld_d;
  logic [31:0] a_iw_q, a_iw_d;
  imm_sel_t    a_sel_q, a_sel_d;
  logic        b_vld_q, b_vld_d;
  logic [31:0] b_iw_q, b_iw_d;
  logic [31:0] b_imm_q, b_imm_d;
  logic [31:0] a_imm;
  logic        a_adv, b_load, b_free, acc;

  eco32_core_ifu_imm_dec u_dec (
    .i_mopc (i_iw[31:26]),
    .i_m    (i_iw[25]),
    .i_p0   (i_p0),
    .o_sel  (dec_sel)
  );

  assign a_imm = imm_mux(a_iw_q[18:0], a_sel_q);

`ifdef ECO32_IFU_IMM_PAIR_EN
  localparam int unsigned CNT_W =
    (HOLD_TMO < 2) ? 1 : $clog2(HOLD_TMO + 1);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(HOLD_TMO);

  pair_st_e         st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      held_iw_q, held_iw_d;
  logic [31:0]      held_imm_q, held_imm_d;
  logic             b_pair_q, b_pair_d;
  logic             a_lo, a_hi;

  assign a_lo = is_pair_opc(a_iw_q[31:26]) &
                ~a_iw_q[25];
  assign a_hi = (a_iw_q[31:26] == held_iw_q[31:26]) &
                a_iw_q[25];
`endif

  always_comb begin
    b_free  = ~b_vld_q | i_rdy;
    a_adv   = 1'b0;
    b_load  = 1'b0;
    b_iw_d  = b_iw_q;
    b_imm_d = b_imm_q;
`ifdef ECO32_IFU_IMM_PAIR_EN
    st_d       = st_q;
    cnt_d      = cnt_q;
    held_iw_d  = held_iw_q;
    held_imm_d = held_imm_q;
    b_pair_d   = b_pair_q;
    unique case (st_q)
      ST_IDLE: begin
        if (a_vld_q && a_lo) begin
          // park the low half; it never occupies B
          a_adv      = 1'b1;
          held_iw_d  = a_iw_q;
          held_imm_d = a_imm;
          st_d       = ST_HOLD;
          cnt_d      = '0;
        end else if (a_vld_q && b_free) begin
          a_adv    = 1'b1;
          b_load   = 1'b1;
          b_iw_d   = a_iw_q;
          b_imm_d  = a_imm;
          b_pair_d = 1'b0;
        end
      end
      ST_HOLD: begin
        if (a_vld_q && a_hi) begin
          if (b_free) begin
            a_adv    = 1'b1;
            b_load   = 1'b1;
            b_iw_d   = a_iw_q;
            b_imm_d  = {a_iw_q[12:0], held_imm_q[18:0]};
            b_pair_d = 1'b1;
            st_d     = ST_IDLE;
          end
        end else if (a_vld_q || cnt_q == TMO) begin
          // A word stays put; it is handled from IDLE
          if (b_free) begin
            b_load   = 1'b1;
            b_iw_d   = held_iw_q;
            b_imm_d  = held_imm_q;
            b_pair_d = 1'b0;
            st_d     = ST_IDLE;
          end
        end
        if (st_d == ST_HOLD && cnt_q != TMO)
          cnt_d = cnt_q + 1'b1;
      end
      default: ;
    endcase
`else
    if (a_vld_q && b_free) begin
      a_adv   = 1'b1;
      b_load  = 1'b1;
      b_iw_d  = a_iw_q;
      b_imm_d = a_imm;
    end
`endif
    o_rdy   = rst_n & ~i_flush & (~a_vld_q | a_adv);
    acc     = i_stb & o_rdy;
    a_vld_d = acc | (a_vld_q & ~a_adv);
    a_iw_d  = acc ? i_iw : a_iw_q;
    a_sel_d = acc ? dec_sel : a_sel_q;
    b_vld_d = b_load | (b_vld_q & ~i_rdy);
    if (i_flush) begin
      a_vld_d = 1'b0;
      b_vld_d = 1'b0;
`ifdef ECO32_IFU_IMM_PAIR_EN
      st_d  = ST_IDLE;
      cnt_d = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_vld_q <= 1'b0;
      a_iw_q  <= '0;
      a_sel_q <= '0;
      b_vld_q <= 1'b0;
      b_iw_q  <= '0;
      b_imm_q <= '0;
    end else begin
      a_vld_q <= a_vld_d;
      a_iw_q  <= a_iw_d;
      a_sel_q <= a_sel_d;
      b_vld_q <= b_vld_d;
      b_iw_q  <= b_iw_d;
      b_imm_q <= b_imm_d;
    end
  end

`ifdef ECO32_IFU_IMM_PAIR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= ST_IDLE;
      cnt_q      <= '0;
      held_iw_q  <= '0;
      held_imm_q <= '0;
      b_pair_q   <= 1'b0;
    end else begin
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      held_iw_q  <= held_iw_d;
      held_imm_q <= held_imm_d;
      b_pair_q   <= b_pair_d;
    end
  end

  assign o_pair = b_pair_q;
`else
  assign o_pair = 1'b0;
`endif

  assign o_stb = b_vld_q;
  assign o_iw  = b_iw_q;
  assign o_imm = b_imm_q;

endmodule

// File: tb/tb_eco32_core_ifu_imm_seq.sv
// Directed bench for eco32_core_ifu_imm_seq: vector table
// plus stall, flush and ldi/lra pairing sequences.
module tb_eco32_core_ifu_imm_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_flush = 1'b0;
  logic        i_stb = 1'b0;
  logic [31:0] i_iw = '0;
  logic        i_p0 = 1'b0;
  logic        i_rdy = 1'b0;
  logic        o_rdy, o_stb, o_pair;
  logic [31:0] o_iw, o_imm;

  eco32_core_ifu_imm_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (i_flush),
    .i_stb   (i_stb),
    .i_iw    (i_iw),
    .i_p0    (i_p0),
    .o_rdy   (o_rdy),
    .o_stb   (o_stb),
    .o_iw    (o_iw),
    .o_imm   (o_imm),
    .o_pair  (o_pair),
    .i_rdy   (i_rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] iw;
    logic        p0;
    logic [31:0] imm;
  } vec_t;

  typedef struct {
    logic [31:0] iw;
    logic [31:0] imm;
    logic        pair;
  } out_t;

  vec_t vecs[$];
  out_t got[$];
  int   n_run = 0;
  int   n_fail = 0;

  localparam logic [31:0] W0 = 32'hE002_20AB;
  localparam logic [31:0] W1 = 32'hE200_0123;

  always @(negedge clk) begin
    out_t o;
    if (rst_n && o_stb && i_rdy) begin
      o.iw   = o_iw;
      o.imm  = o_imm;
      o.pair = o_pair;
      got.push_back(o);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim did not end");
    $fatal(1);
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h",
               nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [31:0] iw,
                      input logic p0);
    logic ok;
    ok = 1'b0;
    i_iw  = iw;
    i_p0  = p0;
    i_stb = 1'b1;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = o_rdy;
      step(1);
    end
    i_stb = 1'b0;
    chk("send_accept", 32'(ok), 32'd1);
  endtask

  task automatic chk_got(input string nm,
                         input int idx,
                         input logic [31:0] eiw,
                         input logic [31:0] eimm,
                         input logic epair);
    if (idx >= got.size()) begin
      n_run++;
      n_fail++;
      $display("FAIL %s: output #%0d missing, have %0d",
               nm, idx, got.size());
    end else begin
      chk({nm, "_iw"}, got[idx].iw, eiw);
      chk({nm, "_imm"}, got[idx].imm, eimm);
      chk({nm, "_pair"}, 32'(got[idx].pair),
          32'(epair));
    end
  endtask

  initial begin
    logic lat0;

    vecs.push_back('{32'h0000_1FFF, 1'b0, 32'hFFFF_FFFF});
    vecs.push_back('{32'h1400_0123, 1'b0, 32'h0000_0123});
    vecs.push_back('{32'h4000_1ABC, 1'b0, 32'hD5E0_0000});
    vecs.push_back('{32'h6407_FFFF, 1'b0, 32'h0000_1FFF});
    vecs.push_back('{32'h6800_1FFF, 1'b0, 32'h0000_0000});
    vecs.push_back('{32'hAC00_1000, 1'b0, 32'hFFFF_F000});
    vecs.push_back('{32'hB000_1003, 1'b0, 32'hFFFF_E018});
    vecs.push_back('{32'hCC00_13FF, 1'b0, 32'h0000_1FF8});
    vecs.push_back('{32'hDC00_13FF, 1'b1, 32'h0000_1FF8});
    vecs.push_back('{32'hC404_0001, 1'b0, 32'hFFFC_0004});
    vecs.push_back('{32'hC404_0001, 1'b1, 32'h0004_0004});
    vecs.push_back('{32'hD404_0001, 1'b0, 32'hFFFC_0004});
    vecs.push_back('{32'hC800_17FF, 1'b0, 32'hFFFF_FFFC});
    vecs.push_back('{32'hC800_17FF, 1'b1, 32'h0000_1FFC});
    vecs.push_back('{{6'h34, 1'b0, 6'h0, 6'h2A, 2'b0,
                      11'h155}, 1'b1,
                     {7'h00, 6'h2A, 6'h2A, 11'h155, 2'b0}});
    vecs.push_back('{{6'h34, 1'b0, 6'h0, 6'h2A, 2'b0,
                      11'h155}, 1'b0,
                     {7'h7F, 6'h2A, 6'h2A, 11'h155, 2'b0}});
    vecs.push_back('{32'hE200_A007, 1'b0, 32'h0038_A000});
    vecs.push_back('{32'hFFFF_FFFF, 1'b1, 32'h0000_0000});
`ifndef ECO32_IFU_IMM_PAIR_EN
    vecs.push_back('{32'hE007_E0AB, 1'b0, 32'hFFFF_E0AB});
`endif

    #2 rst_n = 1'b0;
    step(3);
    @(negedge clk);
    chk("rst_stb", 32'(o_stb), 32'd0);
    chk("rst_iw", o_iw, 32'd0);
    chk("rst_imm", o_imm, 32'd0);
    chk("rst_pair", 32'(o_pair), 32'd0);
    chk("rst_rdy", 32'(o_rdy), 32'd0);
    step(1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rdy", 32'(o_rdy), 32'd1);
    step(1);
    i_rdy = 1'b1;

    foreach (vecs[i]) begin
      i_iw  = vecs[i].iw;
      i_p0  = vecs[i].p0;
      i_stb = 1'b1;
      step(1);
      i_stb = 1'b0;
      @(negedge clk);
      lat0 = o_stb;
      step(1);
      @(negedge clk);
      chk($sformatf("vec%0d_lat", i),
          {30'b0, lat0, o_stb}, 32'd1);
      chk($sformatf("vec%0d_imm", i), o_imm, vecs[i].imm);
      chk($sformatf("vec%0d_iw", i), o_iw, vecs[i].iw);
      chk($sformatf("vec%0d_pair", i), 32'(o_pair), 0);
      step(1);
    end

    // backpressure with three words
    step(2);
    got.delete();
    i_rdy = 1'b0;
    send(32'h0000_0001, 1'b0);
    send(32'h0000_0002, 1'b0);
    i_iw  = 32'h0000_0003;
    i_stb = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_imm", o_imm, 32'd1);
      chk("stall_stb_rdy", {30'b0, o_stb, o_rdy}, 32'd2);
      step(1);
    end
    i_rdy = 1'b1;
    send(32'h0000_0003, 1'b0);
    step(10);
    chk("stall_count", got.size(), 3);
    chk_got("stall0", 0, 32'h1, 32'h1, 1'b0);
    chk_got("stall1", 1, 32'h2, 32'h2, 1'b0);
    chk_got("stall2", 2, 32'h3, 32'h3, 1'b0);

    // flush while B holds a blocked word
    got.delete();
    i_rdy = 1'b0;
    send(32'h0000_0005, 1'b0);
    step(3);
    i_flush = 1'b1;
    @(negedge clk);
    chk("flush_rdy", 32'(o_rdy), 32'd0);
    step(1);
    i_flush = 1'b0;
    i_rdy   = 1'b1;
    step(10);
    chk("flush_drop", got.size(), 0);

`ifdef ECO32_IFU_IMM_PAIR_EN
    got.delete();
    send(W0, 1'b0);
    send(W1, 1'b0);
    step(10);
    chk("pair_count", got.size(), 1);
    chk_got("pair", 0, W1, 32'h091A_20AB, 1'b1);

    got.delete();
    send(W0, 1'b0);
    send(32'h0000_0005, 1'b0);
    step(10);
    chk("brk_count", got.size(), 2);
    chk_got("brk0", 0, W0, 32'h0002_20AB, 1'b0);
    chk_got("brk1", 1, 32'h5, 32'h5, 1'b0);

    got.delete();
    send(W0, 1'b0);
    step(15);
    chk("tmo_early", got.size(), 0);
    step(10);
    chk("tmo_count", got.size(), 1);
    chk_got("tmo", 0, W0, 32'h0002_20AB, 1'b0);

    got.delete();
    send(W0, 1'b0);
    step(4);
    i_flush = 1'b1;
    step(1);
    i_flush = 1'b0;
    step(25);
    chk("hold_flush", got.size(), 0);

    got.delete();
    send(W0, 1'b0);
    step(3);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    send(W1, 1'b0);
    step(10);
    chk("rst_pair_count", got.size(), 1);
    chk_got("rst_hi", 0, W1, 32'h0918_0000, 1'b0);
`else
    got.delete();
    send(W0, 1'b0);
    send(W1, 1'b0);
    step(10);
    chk("nopair_count", got.size(), 2);
    chk_got("nopair0", 0, W0, 32'h0002_20AB, 1'b0);
    chk_got("nopair1", 1, W1, 32'h0918_0000, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
